rv32v_dmem_arbiter: RTL and testbench

- Shares the single data-cache port between the scalar pipeline's memory stage and the vector memory stage.
- Grants one requester at a time and holds the grant until the cache completes the transaction.
- Honours a vector lock so a multi-element vector load/store is not interleaved.
- Bounds scalar starvation with a wait counter. Sits between both memory stages and the cache model interface.

---
 rtl/rv32v_dmem_arbiter.sv | 81 ++++++++
 tb/tb_rv32v_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_dmem_arbiter.sv
// rv32v_dmem_arbiter: shares one data-cache port (m_*) between scalar (s_*) and vector (v_*) memory stages with vector lock and starvation bound
module rv32v_dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_ren,
  input  logic        s_wen,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_byte_en,
  output logic [31:0] s_rdata,
  output logic        s_busy,
  input  logic        v_ren,
  input  logic        v_wen,
  input  logic [31:0] v_addr,
  input  logic [31:0] v_wdata,
  input  logic [3:0]  v_byte_en,
  input  logic        v_lock,
  output logic [31:0] v_rdata,
  output logic        v_busy,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic        grant_v,
  output logic        starve_force
);
  typedef enum logic [1:0] {IDLE, SCALAR, VECTOR} state_t;
  state_t state, state_nxt;
  logic last_v;
  logic [CNT_W-1:0] cnt;
  logic s_req, v_req, own, sel_v, own_req, done, s_done, v_done, s_win;
  assign s_req = s_ren | s_wen;
  assign v_req = v_ren | v_wen;
  assign own = state != IDLE;
  assign sel_v = state == VECTOR;
  assign own_req = own & (sel_v ? v_req : s_req);
  assign done = own_req & ~m_busy;
  assign s_done = done & ~sel_v;
  assign v_done = done & sel_v;
  assign starve_force = cnt >= CNT_W'(STARVE_LIMIT);
  assign grant_v = sel_v;
  assign s_win = s_req & (~v_req | starve_force | last_v);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last_v <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (done) last_v <= sel_v;
      if (!s_req || s_done) cnt <= '0;
      else if (sel_v && v_lock && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = s_win ? SCALAR : v_req ? VECTOR : IDLE;
      SCALAR:  state_nxt = s_req & m_busy ? SCALAR : IDLE;
      VECTOR:  state_nxt = (v_req & m_busy) | (v_lock & ~starve_force) ? VECTOR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    m_wen = own & (sel_v ? v_wen : s_wen);
    m_ren = own & (sel_v ? v_ren & ~v_wen : s_ren & ~s_wen);
    m_addr = own ? (sel_v ? v_addr : s_addr) : '0;
    m_wdata = own ? (sel_v ? v_wdata : s_wdata) : '0;
    m_byte_en = own ? (sel_v ? v_byte_en : s_byte_en) : '0;
    s_busy = s_req & ~s_done;
    v_busy = v_req & ~v_done;
    s_rdata = s_done ? m_rdata : '0;
    v_rdata = v_done ? m_rdata : '0;
  end
endmodule

// File: tb/tb_rv32v_dmem_arbiter.sv
// tb_rv32v_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level memory model
module tb_rv32v_dmem_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic s_ren, s_wen, v_ren, v_wen, v_lock, m_busy;
  logic [31:0] s_addr, s_wdata, v_addr, v_wdata, m_rdata;
  logic [3:0] s_byte_en, v_byte_en;
  logic [31:0] s_rdata, v_rdata, m_addr, m_wdata;
  logic s_busy, v_busy, m_ren, m_wen, grant_v, starve_force;
  logic [3:0] m_byte_en;
  int n_tests = 0, n_fail = 0;
  rv32v_dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata), .s_byte_en(s_byte_en),
    .s_rdata(s_rdata), .s_busy(s_busy),
    .v_ren(v_ren), .v_wen(v_wen), .v_addr(v_addr), .v_wdata(v_wdata), .v_byte_en(v_byte_en),
    .v_lock(v_lock), .v_rdata(v_rdata), .v_busy(v_busy),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_busy(m_busy), .grant_v(grant_v), .starve_force(starve_force)
  );
  always #5 CLK = ~CLK;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction
  task automatic clr();
    s_ren = 0; s_wen = 0; s_addr = 0; s_wdata = 0; s_byte_en = 0;
    v_ren = 0; v_wen = 0; v_addr = 0; v_wdata = 0; v_byte_en = 0; v_lock = 0;
    m_busy = 1; m_rdata = 0;
  endtask
  task automatic rst_dut();
    clr();
    RST = 1;
    @(negedge CLK);
    RST = 0;
  endtask
  task automatic test_reset();
    clr(); RST = 1; s_ren = 1; v_wen = 1;
    @(negedge CLK); @(negedge CLK); #1;
    n_tests++; if (m_ren !== 1'b0) begin n_fail++; $display("FAIL reset_m_ren got %0b want 0", m_ren); end
    n_tests++; if (m_wen !== 1'b0) begin n_fail++; $display("FAIL reset_m_wen got %0b want 0", m_wen); end
    n_tests++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
    n_tests++; if (m_byte_en !== 4'h0) begin n_fail++; $display("FAIL reset_m_byte_en got %h want 0", m_byte_en); end
    n_tests++; if (grant_v !== 1'b0) begin n_fail++; $display("FAIL reset_grant_v got %0b want 0", grant_v); end
    n_tests++; if (starve_force !== 1'b0) begin n_fail++; $display("FAIL reset_starve got %0b want 0", starve_force); end
    n_tests++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL reset_s_busy got %0b want 1", s_busy); end
    n_tests++; if (v_busy !== 1'b1) begin n_fail++; $display("FAIL reset_v_busy got %0b want 1", v_busy); end
    clr(); RST = 0;
    @(negedge CLK);
  endtask
  task automatic test_scalar_read();
    rst_dut(); s_ren = 1; s_addr = 32'h100; #1;
    n_tests++; if (m_ren !== 1'b0) begin n_fail++; $display("FAIL sread_c0_m_ren got %0b want 0", m_ren); end
    @(negedge CLK); #1;
    n_tests++; if (m_ren !== 1'b1) begin n_fail++; $display("FAIL sread_c1_m_ren got %0b want 1", m_ren); end
    n_tests++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL sread_c1_m_addr got %h want 100", m_addr); end
    @(negedge CLK); #1;
    n_tests++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL sread_c2_s_busy got %0b want 1", s_busy); end
    m_busy = 0; m_rdata = 32'hDEADBEEF; #1;
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL sread_c3_s_busy got %0b want 0", s_busy); end
    n_tests++; if (s_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sread_c3_s_rdata got %h want deadbeef", s_rdata); end
    n_tests++; if (v_rdata !== 32'h0) begin n_fail++; $display("FAIL sread_c3_v_rdata got %h want 0", v_rdata); end
    @(negedge CLK); m_busy = 1; #1;
    n_tests++; if (m_ren !== 1'b0) begin n_fail++; $display("FAIL sread_c4_idle_m_ren got %0b want 0", m_ren); end
    n_tests++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL sread_c4_s_rdata got %h want 0", s_rdata); end
    clr();
    @(negedge CLK);
  endtask
  task automatic test_both_pending();
    rst_dut();
    s_wen = 1; s_addr = 32'h200; s_wdata = 32'h11223344; s_byte_en = 4'hF; v_ren = 1; v_addr = 32'h300; #1;
    n_tests++; if (m_wen !== 1'b0) begin n_fail++; $display("FAIL both_arb_m_wen got %0b want 0", m_wen); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b0) begin n_fail++; $display("FAIL both_grant_v got %0b want 0", grant_v); end
    n_tests++; if ({m_wen, m_ren} !== 2'b10) begin n_fail++; $display("FAIL both_m_wen_ren got %b want 10", {m_wen, m_ren}); end
    n_tests++; if (m_addr !== 32'h200) begin n_fail++; $display("FAIL both_m_addr got %h want 200", m_addr); end
    n_tests++; if (m_wdata !== 32'h11223344) begin n_fail++; $display("FAIL both_m_wdata got %h want 11223344", m_wdata); end
    n_tests++; if (m_byte_en !== 4'hF) begin n_fail++; $display("FAIL both_m_byte_en got %h want f", m_byte_en); end
    n_tests++; if (v_busy !== 1'b1) begin n_fail++; $display("FAIL both_v_wait_busy got %0b want 1", v_busy); end
    m_busy = 0; #1;
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL both_s_done got %0b want 0", s_busy); end
    @(negedge CLK); s_wen = 0; m_busy = 1; #1;
    n_tests++; if (grant_v !== 1'b0 || m_ren !== 1'b0) begin n_fail++; $display("FAIL both_idle got grant_v=%0b m_ren=%0b want 0 0", grant_v, m_ren); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b1) begin n_fail++; $display("FAIL both_v_grant got %0b want 1", grant_v); end
    n_tests++; if (m_ren !== 1'b1 || m_addr !== 32'h300) begin n_fail++; $display("FAIL both_v_req got m_ren=%0b addr=%h want 1 300", m_ren, m_addr); end
    m_busy = 0; m_rdata = 32'hCAFEF00D; #1;
    n_tests++; if (v_busy !== 1'b0 || v_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL both_v_done got busy=%0b rdata=%h want 0 cafef00d", v_busy, v_rdata); end
    n_tests++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL both_s_rdata got %h want 0", s_rdata); end
    @(negedge CLK); clr();
    @(negedge CLK);
  endtask
  task automatic test_vector_burst();
    rst_dut(); v_ren = 1; v_lock = 1; v_addr = 32'h1000; m_busy = 0; #1;
    n_tests++; if (grant_v !== 1'b0) begin n_fail++; $display("FAIL burst_arb_grant got %0b want 0", grant_v); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      v_addr = 32'h1000 + 32'(4 * i); m_rdata = 32'h0A000000 + 32'(i); #1;
      n_tests++; if (grant_v !== 1'b1 || m_ren !== 1'b1) begin n_fail++; $display("FAIL burst_grant[%0d] got grant_v=%0b m_ren=%0b want 1 1", i, grant_v, m_ren); end
      n_tests++; if (m_addr !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL burst_addr[%0d] got %h want %h", i, m_addr, 32'h1000 + 32'(4 * i)); end
      n_tests++; if (v_busy !== 1'b0 || v_rdata !== 32'h0A000000 + 32'(i)) begin n_fail++; $display("FAIL burst_done[%0d] got busy=%0b rdata=%h", i, v_busy, v_rdata); end
    end
    @(negedge CLK); v_ren = 0; v_lock = 0; #1;
    n_tests++; if (grant_v !== 1'b1 || m_ren !== 1'b0) begin n_fail++; $display("FAIL burst_hold got grant_v=%0b m_ren=%0b want 1 0", grant_v, m_ren); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b0) begin n_fail++; $display("FAIL burst_release got %0b want 0", grant_v); end
    clr();
    @(negedge CLK);
  endtask
  task automatic test_starvation();
    rst_dut(); v_ren = 1; v_lock = 1; v_addr = 32'h2000; m_busy = 0;
    @(negedge CLK); s_ren = 1; s_addr = 32'h40; #1;
    n_tests++; if (grant_v !== 1'b1 || starve_force !== 1'b0 || s_busy !== 1'b1) begin n_fail++; $display("FAIL starve_start got grant_v=%0b sf=%0b s_busy=%0b want 1 0 1", grant_v, starve_force, s_busy); end
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK); #1;
      n_tests++; if (starve_force !== 1'b0 || grant_v !== 1'b1) begin n_fail++; $display("FAIL starve_wait[%0d] got sf=%0b grant_v=%0b want 0 1", k, starve_force, grant_v); end
    end
    @(negedge CLK); #1;
    n_tests++; if (starve_force !== 1'b1 || grant_v !== 1'b1 || v_busy !== 1'b0) begin n_fail++; $display("FAIL starve_rise got sf=%0b grant_v=%0b v_busy=%0b want 1 1 0", starve_force, grant_v, v_busy); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b0 || m_ren !== 1'b0 || starve_force !== 1'b1) begin n_fail++; $display("FAIL starve_idle got grant_v=%0b m_ren=%0b sf=%0b want 0 0 1", grant_v, m_ren, starve_force); end
    @(negedge CLK); #1;
    n_tests++; if (m_ren !== 1'b1 || m_addr !== 32'h40 || grant_v !== 1'b0) begin n_fail++; $display("FAIL starve_scalar got m_ren=%0b addr=%h grant_v=%0b want 1 40 0", m_ren, m_addr, grant_v); end
    n_tests++; if (s_busy !== 1'b0 || v_busy !== 1'b1) begin n_fail++; $display("FAIL starve_busy got s=%0b v=%0b want 0 1", s_busy, v_busy); end
    s_ren = 0;
    @(negedge CLK); #1;
    n_tests++; if (starve_force !== 1'b0 || grant_v !== 1'b0) begin n_fail++; $display("FAIL starve_clear got sf=%0b grant_v=%0b want 0 0", starve_force, grant_v); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b1) begin n_fail++; $display("FAIL starve_resume got %0b want 1", grant_v); end
    clr();
    @(negedge CLK);
  endtask
  task automatic test_reset_mid_op();
    rst_dut(); v_ren = 1; v_addr = 32'h500; m_busy = 1;
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b1 || m_ren !== 1'b1) begin n_fail++; $display("FAIL rmid_own got grant_v=%0b m_ren=%0b want 1 1", grant_v, m_ren); end
    RST = 1;
    @(negedge CLK); #1;
    n_tests++; if (m_ren !== 1'b0 || grant_v !== 1'b0) begin n_fail++; $display("FAIL rmid_after got m_ren=%0b grant_v=%0b want 0 0", m_ren, grant_v); end
    n_tests++; if (v_busy !== 1'b1 || v_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_busy got v_busy=%0b v_rdata=%h want 1 0", v_busy, v_rdata); end
    RST = 0;
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b1 || m_ren !== 1'b1 || m_addr !== 32'h500) begin n_fail++; $display("FAIL rmid_rearb got grant_v=%0b m_ren=%0b addr=%h want 1 1 500", grant_v, m_ren, m_addr); end
    m_busy = 0; m_rdata = 32'h00005A5A; #1;
    n_tests++; if (v_busy !== 1'b0 || v_rdata !== 32'h00005A5A) begin n_fail++; $display("FAIL rmid_done got busy=%0b rdata=%h want 0 5a5a", v_busy, v_rdata); end
    @(negedge CLK); clr();
    @(negedge CLK);
  endtask
  task automatic test_abort_both_set();
    rst_dut(); s_ren = 1; s_addr = 32'h80; m_busy = 1;
    @(negedge CLK); #1;
    n_tests++; if (m_ren !== 1'b1) begin n_fail++; $display("FAIL abort_own got %0b want 1", m_ren); end
    @(negedge CLK); s_ren = 0;
    @(negedge CLK); s_ren = 1; s_wen = 1; v_ren = 1; v_addr = 32'h90; #1;
    n_tests++; if (m_ren !== 1'b0 || m_wen !== 1'b0) begin n_fail++; $display("FAIL abort_idle got m_ren=%0b m_wen=%0b want 0 0", m_ren, m_wen); end
    @(negedge CLK); #1;
    n_tests++; if (grant_v !== 1'b0) begin n_fail++; $display("FAIL abort_rr_kept got grant_v=%0b want 0", grant_v); end
    n_tests++; if ({m_wen, m_ren} !== 2'b10 || m_addr !== 32'h80) begin n_fail++; $display("FAIL abort_both_set got wen_ren=%b addr=%h want 10 80", {m_wen, m_ren}, m_addr); end
    m_busy = 0; #1;
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL abort_done got %0b want 0", s_busy); end
    @(negedge CLK); clr();
    @(negedge CLK);
  endtask
  task automatic test_random();
    logic [31:0] cmem [16];
    logic [31:0] rmem [16];
    logic c_act, m_done, s_cmp, v_cmp;
    int c_lat, burst, s_wait, v_wait, s_cnt, v_cnt;
    c_act = 0; c_lat = 0; burst = 0; s_wait = 0; v_wait = 0; s_cnt = 0; v_cnt = 0;
    for (int i = 0; i < 16; i++) begin cmem[i] = $urandom; rmem[i] = cmem[i]; end
    rst_dut();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (m_ren | m_wen) begin
        if (!c_act) begin c_act = 1; c_lat = $urandom_range(0, 2); end
        m_busy = c_lat != 0;
        if (c_lat != 0) c_lat--; else c_act = 0;
        m_rdata = cmem[m_addr[5:2]];
      end else begin
        c_act = 0; m_busy = 1'($urandom); m_rdata = $urandom;
      end
      #1;
      m_done = (m_ren | m_wen) & ~m_busy;
      if (m_done && m_wen) cmem[m_addr[5:2]] = merge(cmem[m_addr[5:2]], m_wdata, m_byte_en);
      s_cmp = (s_ren | s_wen) & ~s_busy;
      v_cmp = (v_ren | v_wen) & ~v_busy;
      if (s_cmp) begin
        s_cnt++;
        if (s_wen) rmem[s_addr[5:2]] = merge(rmem[s_addr[5:2]], s_wdata, s_byte_en);
        else begin
          n_tests++; if (s_rdata !== rmem[s_addr[5:2]]) begin n_fail++; $display("FAIL rand_s_rdata cyc %0d got %h want %h", cyc, s_rdata, rmem[s_addr[5:2]]); end
        end
      end
      if (v_cmp) begin
        v_cnt++;
        if (v_wen) rmem[v_addr[5:2]] = merge(rmem[v_addr[5:2]], v_wdata, v_byte_en);
        else begin
          n_tests++; if (v_rdata !== rmem[v_addr[5:2]]) begin n_fail++; $display("FAIL rand_v_rdata cyc %0d got %h want %h", cyc, v_rdata, rmem[v_addr[5:2]]); end
        end
      end
      if (m_done || s_cmp || v_cmp) begin
        n_tests++; if (int'(m_done) != int'(s_cmp) + int'(v_cmp)) begin n_fail++; $display("FAIL rand_completion cyc %0d got cache=%0b s=%0b v=%0b", cyc, m_done, s_cmp, v_cmp); end
      end
      s_wait = ((s_ren | s_wen) && s_busy) ? s_wait + 1 : 0;
      v_wait = ((v_ren | v_wen) && v_busy) ? v_wait + 1 : 0;
      if (s_wait > 80) begin n_tests++; n_fail++; $display("FAIL rand_s_timeout cyc %0d got waiting want done", cyc); s_ren = 0; s_wen = 0; s_wait = 0; end
      if (v_wait > 80) begin n_tests++; n_fail++; $display("FAIL rand_v_timeout cyc %0d got waiting want done", cyc); v_ren = 0; v_wen = 0; v_lock = 0; burst = 0; v_wait = 0; end
      if (s_cmp || !(s_ren | s_wen)) begin
        s_ren = 0; s_wen = 0;
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0: s_ren = 1;
            1: s_wen = 1;
            default: begin s_ren = 1; s_wen = 1; end
          endcase
          s_addr = {26'h0, 4'($urandom), 2'b0}; s_wdata = $urandom; s_byte_en = 4'($urandom);
        end
      end
      if (v_cmp || !(v_ren | v_wen)) begin
        if (v_cmp) burst--;
        if (burst <= 0) begin burst = 0; v_lock = 0; end
        v_ren = 0; v_wen = 0;
        if (burst == 0 && $urandom_range(0, 2) == 0) begin
          burst = $urandom_range(1, 4);
          v_lock = burst > 1;
        end
        if (burst > 0 && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) == 1) v_wen = 1; else v_ren = 1;
          v_addr = {26'h0, 4'($urandom), 2'b0}; v_wdata = $urandom; v_byte_en = 4'($urandom);
        end
      end
    end
    n_tests++; if (s_cnt < 50 || v_cnt < 50) begin n_fail++; $display("FAIL rand_progress got s=%0d v=%0d want >=50 each", s_cnt, v_cnt); end
    clr();
    @(negedge CLK);
  endtask
  initial begin
    clr();
    test_reset();
    test_scalar_read();
    test_both_pending();
    test_vector_burst();
    test_starvation();
    test_reset_mid_op();
    test_abort_both_set();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
